// File: rtl/hls_run_sequencer.sv
// Run controller for a Bambu start_port/done_port accelerator: resets and starts the DUT,
// measures per-run latency with a timeout, and streams one result record per run.
module hls_run_sequencer #(
    parameter int unsigned RUNS_W        = 8,
    parameter int unsigned CYCLE_W       = 32,
    parameter int unsigned TIMEOUT       = 200000000,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cfg_start,
    input  logic [RUNS_W-1:0]  cfg_num_runs,
    input  logic               abort,
    output logic               dut_reset,
    output logic               start_port,
    input  logic               done_port,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [1:0]         res_status,
    output logic [CYCLE_W-1:0] res_cycles,
    output logic [RUNS_W-1:0]  res_run,
    output logic               busy,
    output logic               all_done
);

    localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CYCLE_W-1:0]  TimeoutVal = CYCLE_W'(TIMEOUT);
    localparam logic [SETTLE_W-1:0] SettleLast = SETTLE_W'(SETTLE_CYCLES - 1);

    localparam logic [1:0] StatusDone    = 2'b01;
    localparam logic [1:0] StatusTimeout = 2'b10;
    localparam logic [1:0] StatusAbort   = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StLaunch,
        StWait,
        StReport,
        StFinish
    } state_e;

    state_e               state_q, state_d;
    logic [SETTLE_W-1:0]  settle_q, settle_d;
    logic [CYCLE_W-1:0]   count_q, count_d;
    logic [RUNS_W-1:0]    num_runs_q, num_runs_d;
    logic [RUNS_W-1:0]    run_q, run_d;
    logic [1:0]           status_q, status_d;
    logic [CYCLE_W-1:0]   cycles_q, cycles_d;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= StIdle;
            settle_q   <= '0;
            count_q    <= '0;
            num_runs_q <= '0;
            run_q      <= '0;
            status_q   <= '0;
            cycles_q   <= '0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            count_q    <= count_d;
            num_runs_q <= num_runs_d;
            run_q      <= run_d;
            status_q   <= status_d;
            cycles_q   <= cycles_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        count_d    = count_q;
        num_runs_d = num_runs_q;
        run_d      = run_q;
        status_d   = status_q;
        cycles_d   = cycles_q;

        unique case (state_q)
            StIdle: begin
                if (cfg_start) begin
                    if (cfg_num_runs == '0) begin
                        state_d = StFinish;
                    end else begin
                        num_runs_d = cfg_num_runs;
                        run_d      = '0;
                        settle_d   = '0;
                        count_d    = '0;
                        state_d    = StSettle;
                    end
                end
            end
            StSettle: begin
                if (abort) begin
                    status_d = StatusAbort;
                    cycles_d = count_q;
                    state_d  = StReport;
                end else if (settle_q == SettleLast) begin
                    count_d = CYCLE_W'(1);
                    state_d = StLaunch;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            StLaunch: begin
                // done_port is deliberately not looked at in the start cycle
                if (abort) begin
                    status_d = StatusAbort;
                    cycles_d = count_q;
                    state_d  = StReport;
                end else begin
                    count_d = count_q + 1'b1;
                    state_d = StWait;
                end
            end
            StWait: begin
                // abort beats done, done beats timeout
                if (abort) begin
                    status_d = StatusAbort;
                    cycles_d = count_q;
                    state_d  = StReport;
                end else if (done_port) begin
                    status_d = StatusDone;
                    cycles_d = count_q;
                    state_d  = StReport;
                end else if (count_q == TimeoutVal) begin
                    status_d = StatusTimeout;
                    cycles_d = TimeoutVal;
                    state_d  = StReport;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            StReport: begin
                if (res_ready) begin
                    if (status_q == StatusDone && run_q != num_runs_q - 1'b1) begin
                        run_d    = run_q + 1'b1;
                        settle_d = '0;
                        count_d  = '0;
                        state_d  = StSettle;
                    end else begin
                        state_d = StFinish;
                    end
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Every output is a decode of flopped state, so inputs never reach outputs combinationally.
    assign dut_reset  = (state_q == StLaunch) || (state_q == StWait) || (state_q == StReport);
    assign start_port = (state_q == StLaunch);
    assign res_valid  = (state_q == StReport);
    assign res_status = status_q;
    assign res_cycles = cycles_q;
    assign res_run    = run_q;
    assign busy       = (state_q != StIdle);
    assign all_done   = (state_q == StFinish);

endmodule
